// File: rtl/psi_index_decoder_if.sv
// Bitmap-in / index-stream-out bundle for psi_index_decoder.
// Signal suffixes are from the decoder's point of view.
interface psi_index_decoder_if #(
    parameter int W  = 10,
    parameter int IW = 4
);
    logic [W-1:0]  bitmap_i;
    logic          load_i;
    logic          busy_o;
    logic [IW-1:0] idx_o;
    logic          idx_valid_o;
    logic          idx_ready_i;
    logic          last_o;
    logic          done_o;
    logic [IW:0]   count_o;

    modport slave (
        input  bitmap_i, load_i, idx_ready_i,
        output busy_o, idx_o, idx_valid_o, last_o, done_o, count_o
    );

    modport master (
        output bitmap_i, load_i, idx_ready_i,
        input  busy_o, idx_o, idx_valid_o, last_o, done_o, count_o
    );
endinterface

// File: rtl/psi_index_decoder.sv
// Turns a captured intersection bitmap into a stream of set-bit indices.
// Define PSI_DEC_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
module psi_index_decoder #(
    parameter int W  = 10,
    parameter int IW = 4
) (
    input  logic               clk,
    input  logic               rst,
    psi_index_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  shadow_q, shadow_d;
    logic [IW:0]   count_q, count_d;

    logic [IW-1:0] enc;
    logic [W-1:0]  sel_oh;
    logic          one_left;
    logic          run;

    // Priority encoder: the last match in loop order wins.
    always_comb begin
        enc = '0;
`ifdef PSI_DEC_MSB_FIRST_EN
        for (int i = 0; i < W; i++) begin
            if (shadow_q[i]) enc = IW'(i);
        end
`else
        for (int i = W - 1; i >= 0; i--) begin
            if (shadow_q[i]) enc = IW'(i);
        end
`endif
        sel_oh = W'(1) << enc;
    end

    assign one_left = ((shadow_q & (shadow_q - W'(1))) == '0);
    assign run      = (state_q == S_RUN);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load_i) begin
                    shadow_d = bus.bitmap_i;
                    count_d  = '0;
                    state_d  = (bus.bitmap_i != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (bus.idx_ready_i) begin
                    shadow_d = shadow_q & ~sel_oh;
                    count_d  = count_q + (IW+1)'(1);
                    if (one_left) state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.idx_valid_o = run;
    assign bus.idx_o       = run ? enc : '0;
    assign bus.last_o      = run & one_left;
    assign bus.done_o      = (state_q == S_FIN);
    assign bus.count_o     = count_q;
endmodule

// File: tb/tb_psi_index_decoder.sv
// Directed bench for psi_index_decoder (W=10, IW=4); honours PSI_DEC_MSB_FIRST_EN.
module tb_psi_index_decoder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    psi_index_decoder_if #(.W(10), .IW(4)) bus ();

    psi_index_decoder #(.W(10), .IW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idx(input string tag, input int idx, input bit last, input int cnt);
        chk({tag, " valid"}, bus.idx_valid_o, 1);
        chk({tag, " idx"},   bus.idx_o, idx);
        chk({tag, " last"},  bus.last_o, last);
        chk({tag, " done"},  bus.done_o, 0);
        chk({tag, " count"}, bus.count_o, cnt);
    endtask

    task automatic chk_done(input string tag, input int cnt);
        chk({tag, " done"},  bus.done_o, 1);
        chk({tag, " valid"}, bus.idx_valid_o, 0);
        chk({tag, " idx0"},  bus.idx_o, 0);
        chk({tag, " busy"},  bus.busy_o, 1);
        chk({tag, " count"}, bus.count_o, cnt);
        tick();
        chk({tag, " idle busy"}, bus.busy_o, 0);
        chk({tag, " idle done"}, bus.done_o, 0);
        chk({tag, " hold count"}, bus.count_o, cnt);
    endtask

    task automatic load(input logic [9:0] bm);
        bus.bitmap_i = bm;
        bus.load_i   = 1'b1;
        tick();
        bus.load_i   = 1'b0;
    endtask

    int asc_exp [4];
    int bp_exp  [2];

    initial begin
`ifdef PSI_DEC_MSB_FIRST_EN
        asc_exp = '{9, 5, 2, 0};
        bp_exp  = '{9, 0};
`else
        asc_exp = '{0, 2, 5, 9};
        bp_exp  = '{0, 9};
`endif
        rst = 1'b1;
        bus.bitmap_i    = '0;
        bus.load_i      = 1'b0;
        bus.idx_ready_i = 1'b0;
        tick();
        tick();
        chk("rst busy",  bus.busy_o, 0);
        chk("rst valid", bus.idx_valid_o, 0);
        chk("rst idx",   bus.idx_o, 0);
        chk("rst last",  bus.last_o, 0);
        chk("rst done",  bus.done_o, 0);
        chk("rst count", bus.count_o, 0);
        rst = 1'b0;
        tick();
        chk("idle ready-early valid", bus.idx_valid_o, 0);

        // Scan of 10'b10_0010_0101 with ready held high.
        bus.idx_ready_i = 1'b1;
        load(10'b10_0010_0101);
        for (int i = 0; i < 4; i++) begin
            chk_idx($sformatf("asc%0d", i), asc_exp[i], i == 3, i);
            tick();
        end
        chk_done("asc", 4);

        // Empty bitmap: straight to done, busy for one cycle.
        load(10'b0);
        chk_done("empty", 0);

        // Backpressure on the first index.
        bus.idx_ready_i = 1'b0;
        load(10'b10_0000_0001);
        for (int c = 0; c < 3; c++) begin
            chk_idx($sformatf("bp stall%0d", c), bp_exp[0], 0, 0);
            if (c < 2) tick();
        end
        bus.idx_ready_i = 1'b1;
        tick();
        chk_idx("bp second", bp_exp[1], 1, 1);
        tick();
        chk_done("bp", 2);

        // Full bitmap; a mid-stream load must be ignored.
        load(10'h3FF);
        for (int i = 0; i < 10; i++) begin
`ifdef PSI_DEC_MSB_FIRST_EN
            chk_idx($sformatf("full%0d", i), 9 - i, i == 9, i);
`else
            chk_idx($sformatf("full%0d", i), i, i == 9, i);
`endif
            bus.load_i   = (i == 4);
            bus.bitmap_i = 10'h001;
            tick();
        end
        bus.load_i = 1'b0;
        chk_done("full", 10);

        // Reset after three handshakes, with a load held alongside it.
        load(10'h3FF);
        tick();
        tick();
        tick();
        chk("rstmid pre count", bus.count_o, 3);
        rst          = 1'b1;
        bus.load_i   = 1'b1;
        bus.bitmap_i = 10'h010;
        tick();
        rst        = 1'b0;
        bus.load_i = 1'b0;
        chk("rstmid busy",  bus.busy_o, 0);
        chk("rstmid valid", bus.idx_valid_o, 0);
        chk("rstmid idx",   bus.idx_o, 0);
        chk("rstmid last",  bus.last_o, 0);
        chk("rstmid done",  bus.done_o, 0);
        chk("rstmid count", bus.count_o, 0);
        tick();
        chk("rstmid no done", bus.done_o, 0);
        chk("rstmid still idle", bus.busy_o, 0);
        load(10'h004);
        chk_idx("after rst", 2, 1, 0);
        tick();
        chk_done("after rst", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
